// File: rtl/io_port_unit_if.sv
// ---------------------------------------------------------------------------
// io_port_unit_if
// Bundles the two sides of the I/O port unit.
//   Processor side : outPortData/outSignalEn (OUT instruction write),
//                    inPortData (input word), interruptSignal (2-bit code).
//   Device side    : devInData/devInValid/devInReady (input handshake),
//                    devOutData/devOutValid/devOutReady (output FIFO drain).
// Modports:
//   slave  - the io_port_unit itself
//   master - the environment (processor + external device)
// ---------------------------------------------------------------------------
interface io_port_unit_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] outPortData;
    logic                  outSignalEn;
    logic [DATA_WIDTH-1:0] inPortData;
    logic [1:0]            interruptSignal;
    logic [DATA_WIDTH-1:0] devInData;
    logic                  devInValid;
    logic                  devInReady;
    logic [DATA_WIDTH-1:0] devOutData;
    logic                  devOutValid;
    logic                  devOutReady;

    modport slave (
        input  outPortData, outSignalEn, devInData, devInValid, devOutReady,
        output inPortData, interruptSignal, devInReady, devOutData, devOutValid
    );

    modport master (
        output outPortData, outSignalEn, devInData, devInValid, devOutReady,
        input  inPortData, interruptSignal, devInReady, devOutData, devOutValid
    );
endinterface

// File: rtl/io_port_unit.sv
// ---------------------------------------------------------------------------
// io_port_unit
// Peripheral-side I/O port unit. Presents external input words to the
// processor with an input-ready interrupt, and buffers OUT-instruction
// writes in a small FIFO drained by the external device.
//
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous, active-high, clears all state
//   bus   - io_port_unit_if.slave (processor and device signals)
//
// Interrupt codes (one cycle wide, registered):
//   00 none, 01 input ready, 10 output FIFO became full, 11 output overflow
//
// Build option:
//   IO_OVERFLOW_IRQ_EN - when defined, a write dropped because the FIFO is
//                        full raises code 11; otherwise it is dropped silently.
// ---------------------------------------------------------------------------
module io_port_unit #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic           clk,
    input  logic           reset,
    io_port_unit_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ALMOST_FULL = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] ONE_COUNT   = CW'(1);
    localparam logic [CW-1:0] ZERO_COUNT  = CW'(0);
    localparam logic [PW-1:0] PTR_ONE     = PW'(1);
    localparam logic [HW-1:0] HOLD_LOAD   = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } inState_t;

    // ---------------- input side ----------------
    inState_t              stateR, stateNext;
    logic [HW-1:0]         holdR, holdNext;
    logic                  readyR;
    logic [DATA_WIDTH-1:0] inDataR;
    logic                  accept;

    // readyR is low during reset, so the first accept happens no earlier
    // than the second edge after release.
    assign accept = readyR && bus.devInValid;

    // Input FSM next-state and hold counter
    always_comb begin
        stateNext = stateR;
        holdNext  = holdR;
        case (stateR)
            IDLE: begin
                if (accept) stateNext = PULSE;
                else        stateNext = IDLE;
            end
            PULSE: begin
                holdNext  = HOLD_LOAD;
                stateNext = HOLD;
            end
            HOLD: begin
                if (holdR == HOLD_LAST) stateNext = IDLE;
                else                    holdNext  = holdR - HOLD_LAST;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Input FSM state, ready flag and latched input word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateR  <= IDLE;
            holdR   <= '0;
            readyR  <= 1'b0;
            inDataR <= '0;
        end else begin
            stateR <= stateNext;
            holdR  <= holdNext;
            readyR <= (stateNext == IDLE);
            if (accept) inDataR <= bus.devInData;
            else        inDataR <= inDataR;
        end
    end

    // ---------------- output FIFO ----------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         rdPtrR, wrPtrR;
    logic [CW-1:0]         countR, countNext;
    logic                  validR;
    logic [DATA_WIDTH-1:0] headR, headNext;
    logic                  full, pop, push, fullEvent;

    assign full      = (countR == FULL_COUNT);
    assign pop       = validR && bus.devOutReady;
    assign push      = bus.outSignalEn && (!full || pop);
    assign fullEvent = push && !pop && (countR == ALMOST_FULL);

    // Occupancy after this edge
    always_comb begin
        countNext = countR;
        case ({push, pop})
            2'b10:   countNext = countR + ONE_COUNT;
            2'b01:   countNext = countR - ONE_COUNT;
            default: countNext = countR;
        endcase
    end

    // Next head word: kept in a register so devOutData never depends
    // combinationally on outPortData.
    always_comb begin
        headNext = headR;
        if (pop && (countR == ONE_COUNT)) begin
            // last entry leaves; a simultaneous push becomes the new head
            if (push) headNext = bus.outPortData;
            else      headNext = headR;
        end else if (pop) begin
            headNext = mem[rdPtrR + PTR_ONE];
        end else if (push && (countR == ZERO_COUNT)) begin
            headNext = bus.outPortData;
        end else begin
            headNext = headR;
        end
    end

    // FIFO storage; contents are invalidated by the pointers on reset
    always_ff @(posedge clk) begin
        if (push) mem[wrPtrR] <= bus.outPortData;
    end

    // FIFO pointers, occupancy, valid flag and head register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtrR <= '0;
            wrPtrR <= '0;
            countR <= '0;
            validR <= 1'b0;
            headR  <= '0;
        end else begin
            if (pop)  rdPtrR <= rdPtrR + PTR_ONE;
            if (push) wrPtrR <= wrPtrR + PTR_ONE;
            countR <= countNext;
            validR <= (countNext != ZERO_COUNT);
            headR  <= headNext;
        end
    end

    // ---------------- interrupt arbiter ----------------
    logic       pendInR, pendFullR;
    logic       clrIn, clrFull;
    logic [1:0] irqR, irqNext;
`ifdef IO_OVERFLOW_IRQ_EN
    logic       pendOvfR, clrOvf, ovfEvent;

    assign ovfEvent = bus.outSignalEn && full && !pop;
`endif

    // Emit the highest pending code (11 > 01 > 10) and retire its bit
    always_comb begin
        irqNext = 2'b00;
        clrIn   = 1'b0;
        clrFull = 1'b0;
`ifdef IO_OVERFLOW_IRQ_EN
        clrOvf  = 1'b0;
        if (pendOvfR) begin
            irqNext = 2'b11;
            clrOvf  = 1'b1;
        end else
`endif
        if (pendInR) begin
            irqNext = 2'b01;
            clrIn   = 1'b1;
        end else if (pendFullR) begin
            irqNext = 2'b10;
            clrFull = 1'b1;
        end else begin
            irqNext = 2'b00;
        end
    end

    // Pending bits: a new event re-sets its bit even if it is being retired
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pendInR   <= 1'b0;
            pendFullR <= 1'b0;
            irqR      <= 2'b00;
`ifdef IO_OVERFLOW_IRQ_EN
            pendOvfR  <= 1'b0;
`endif
        end else begin
            pendInR   <= (pendInR && !clrIn) || accept;
            pendFullR <= (pendFullR && !clrFull) || fullEvent;
            irqR      <= irqNext;
`ifdef IO_OVERFLOW_IRQ_EN
            pendOvfR  <= (pendOvfR && !clrOvf) || ovfEvent;
`endif
        end
    end

    assign bus.inPortData      = inDataR;
    assign bus.interruptSignal = irqR;
    assign bus.devInReady      = readyR;
    assign bus.devOutData      = headR;
    assign bus.devOutValid     = validR;

endmodule

// File: tb/tb_io_port_unit.sv
// ---------------------------------------------------------------------------
// tb_io_port_unit
// Directed scenarios followed by random traffic, every cycle compared with a
// queue-based reference model of the port unit.
// ---------------------------------------------------------------------------
module tb_io_port_unit;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int HOLD  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    io_port_unit_if #(.DATA_WIDTH(DW)) bus ();

    io_port_unit #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [DW-1:0] mQ [$];
    logic [DW-1:0] mIn;
    logic [1:0]    mIrq;
    bit            p11, p01, p10;
    int            mBlock;
    bit            mReady;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        chk("inPortData", bus.inPortData, mIn);
        chk("interruptSignal", DW'(bus.interruptSignal), DW'(mIrq));
        chk("devInReady", DW'(bus.devInReady), DW'(mReady));
        chk("devOutValid", DW'(bus.devOutValid), DW'(mQ.size() != 0));
        if (mQ.size() != 0) chk("devOutData", bus.devOutData, mQ[0]);
    endtask

    task automatic modelReset();
        mQ.delete();
        mIn = '0; mIrq = 2'b00;
        p11 = 1'b0; p01 = 1'b0; p10 = 1'b0;
        mBlock = 0; mReady = 1'b0;
    endtask

    // One rising edge of the unit, described by the behavioural rules
    task automatic modelEdge(input bit inValid, input logic [DW-1:0] inData,
                             input bit en, input logic [DW-1:0] wData, input bit outReady);
        bit acc, pop, fits;
        acc  = mReady && inValid;
        pop  = (mQ.size() != 0) && outReady;
        fits = (mQ.size() < DEPTH) || pop;
        if (p11)      begin mIrq = 2'b11; p11 = 1'b0; end
        else if (p01) begin mIrq = 2'b01; p01 = 1'b0; end
        else if (p10) begin mIrq = 2'b10; p10 = 1'b0; end
        else          mIrq = 2'b00;
        if (acc) begin mIn = inData; p01 = 1'b1; end
        if (en && fits && !pop && mQ.size() == DEPTH - 1) p10 = 1'b1;
`ifdef IO_OVERFLOW_IRQ_EN
        if (en && !fits) p11 = 1'b1;
`endif
        if (pop) void'(mQ.pop_front());
        if (en && fits) mQ.push_back(wData);
        if (acc) mBlock = HOLD + 1;
        else if (mBlock > 0) mBlock--;
        mReady = (mBlock == 0);
    endtask

    // Drive inputs, take one edge, check all outputs on the falling edge
    task automatic cycle(input bit inValid, input logic [DW-1:0] inData,
                         input bit en, input logic [DW-1:0] wData, input bit outReady);
        bus.devInValid  = inValid;
        bus.devInData   = inData;
        bus.outSignalEn = en;
        bus.outPortData = wData;
        bus.devOutReady = outReady;
        @(posedge clk);
        modelEdge(inValid, inData, en, wData, outReady);
        @(negedge clk);
        checkAll();
    endtask

    task automatic doReset(input int holdCycles);
        reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        chk("resetHead", bus.devOutData, 16'd0);
        repeat (holdCycles) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int lows, ones;
        reset           = 1'b0;
        bus.devInValid  = 1'b1;
        bus.devInData   = 16'd10;
        bus.outSignalEn = 1'b0;
        bus.outPortData = 16'd0;
        bus.devOutReady = 1'b0;
        @(negedge clk);

        // reset with an input word already offered
        doReset(2);
        cycle(1'b1, 16'd10, 1'b0, 16'd0, 1'b0);
        chk("readyAfterRelease", DW'(bus.devInReady), 16'd1);
        cycle(1'b1, 16'd10, 1'b0, 16'd0, 1'b0);
        chk("firstAccept", bus.inPortData, 16'd10);
        lows = (bus.devInReady == 1'b0) ? 1 : 0;
        ones = (bus.interruptSignal == 2'b01) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
            if (bus.devInReady == 1'b0) lows++;
            if (bus.interruptSignal == 2'b01) ones++;
        end
        chk("readyLowCycles", DW'(lows), DW'(1 + HOLD));
        chk("inIrqPulses", DW'(ones), 16'd1);

        // fill the FIFO, full pulse, dropped fifth write, in-order drain
        for (int k = 1; k <= 4; k++) cycle(1'b0, 16'd0, 1'b1, DW'(k), 1'b0);
        cycle(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
        chk("fullIrq", DW'(bus.interruptSignal), 16'd2);
        cycle(1'b0, 16'd0, 1'b1, 16'd5, 1'b0);
        cycle(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
`ifdef IO_OVERFLOW_IRQ_EN
        chk("ovfIrq", DW'(bus.interruptSignal), 16'd3);
`else
        chk("ovfIrq", DW'(bus.interruptSignal), 16'd0);
`endif
        for (int k = 1; k <= 4; k++) begin
            chk("drainOrder", bus.devOutData, DW'(k));
            cycle(1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
        end
        chk("drainedEmpty", DW'(bus.devOutValid), 16'd0);

        // simultaneous push and pop while full
        for (int k = 12; k <= 15; k++) cycle(1'b0, 16'd0, 1'b1, DW'(k), 1'b0);
        cycle(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
        cycle(1'b0, 16'd0, 1'b1, 16'd9, 1'b1);
        chk("pushPopHead", bus.devOutData, 16'd13);
        cycle(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
        chk("pushPopNoIrq", DW'(bus.interruptSignal), 16'd0);
        cycle(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
        chk("pushPopNoIrq2", DW'(bus.interruptSignal), 16'd0);

        // input accept and overflow on the same edge
        cycle(1'b1, 16'h0077, 1'b1, 16'h00AA, 1'b0);
        cycle(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
`ifdef IO_OVERFLOW_IRQ_EN
        chk("sameEdgeFirst", DW'(bus.interruptSignal), 16'd3);
        cycle(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
`endif
        chk("sameEdgeIn", DW'(bus.interruptSignal), 16'd1);
        for (int k = 0; k < 4; k++) cycle(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);

        // reset with 3 entries queued and a pending input interrupt
        cycle(1'b1, 16'h0055, 1'b0, 16'd0, 1'b1);
        chk("preResetCount", DW'(mQ.size()), 16'd3);
        doReset(1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
            chk("noStaleIrq", DW'(bus.interruptSignal), 16'd0);
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 2) != 0),
                  DW'($urandom), 1'($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/io_port_unit.md
# io_port_unit

Peripheral-side I/O port unit at the far end of the processor's port interface. Drives the processor's `inPortData` and `interruptSignal` and consumes its `outPortData`/`outSignalEn`. Input words from an external device are presented to the processor with an input-ready interrupt. Words written by OUT instructions are buffered in a small FIFO that the external device drains over a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 16, port word width
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2
- `HOLD_CYCLES`, 3, cycles after an input interrupt before the next input word is accepted; ≥1

- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `outPortData`  in  DATA_WIDTH  word from the processor OUT instruction
- `outSignalEn`  in  1  one-cycle write strobe for `outPortData`
- `inPortData`  out  DATA_WIDTH  registered input word presented to the processor
- `interruptSignal`  out  2  one-cycle interrupt code: 00 none, 01 input ready, 10 output FIFO became full, 11 output overflow
- `devInData`  in  DATA_WIDTH  external input word
- `devInValid`  in  1  external input word valid
- `devInReady`  out  1  unit can accept an input word
- `devOutData`  out  DATA_WIDTH  head of output FIFO
- `devOutValid`  out  1  FIFO non-empty
- `devOutReady`  in  1  external sink accepts head

## Operation
- Input FSM, states IDLE, PULSE, HOLD:
  - IDLE: `devInReady`=1. On `devInValid`, latch `devInData` into `inPortData`, set pending-01, go to PULSE.
  - PULSE: `devInReady`=0. Load hold counter with HOLD_CYCLES, go to HOLD.
  - HOLD: `devInReady`=0. Decrement each cycle; at 1, go to IDLE.
  - `inPortData` holds its value until the next accepted word.
- Output FIFO:
  - Pop when `devOutValid && devOutReady`.
  - Push when `outSignalEn` and (not full, or pop in the same cycle).
  - Push and pop in the same cycle when full: both occur, and occupancy is unchanged.
  - Push when full with no pop: word dropped, and overflow event raised.
  - Pointers wrap modulo FIFO_DEPTH. The count register is log2(FIFO_DEPTH)+1 bits wide.
- Full event: pending-10 is set on the cycle occupancy transitions from FIFO_DEPTH-1 to FIFO_DEPTH. It is not set while the FIFO stays full.
- Interrupt arbiter:
  - Pending bits for 11, 01 and 10.
  - Each cycle, the registered `interruptSignal` carries the highest pending code (priority 11 > 01 > 10), and that bit clears.
  - Lower codes wait one or more cycles, never lost.
  - An event arriving while its own bit is already pending merges into that bit.

## Timing
- Reset values:
  - `inPortData`=0, `interruptSignal`=00.
  - `devInReady`=0 while reset is high, 1 the cycle after release (FSM in IDLE).
  - `devOutValid`=0, `devOutData`=0.
  - FIFO empty; all pending bits clear.
- Reset mid-operation discards FIFO contents, pending interrupts and the hold count.
- Input latency:
  - Word accepted on edge N is visible on `inPortData` after edge N.
  - `interruptSignal`=01 for the cycle after edge N+1, provided no 11 is pending.
  - Next accept earliest at edge N+2+HOLD_CYCLES.
- Output latency: word pushed on edge N gives `devOutValid`=1 and `devOutData`=word after edge N when the FIFO was empty. The head is registered, not combinational from `outPortData`.
- `devOutData` is stable while `devOutValid`=1 and `devOutReady`=0.
- Interrupt codes are always exactly one cycle wide. Back-to-back distinct codes are legal.

## Configuration
- `IO_OVERFLOW_IRQ_EN` defined: a dropped write sets pending-11, and code 11 is emitted as above.
- `IO_OVERFLOW_IRQ_EN` undefined: a dropped write is silently discarded, the pending-11 bit does not exist, and `interruptSignal` never shows 11. FIFO behaviour is otherwise identical.

## Test plan
- Reset with `devInValid`=1 and `devInData`=16'd10, then release. Required: `inPortData`=10 one cycle after first accept; `interruptSignal`=01 for exactly one cycle; `devInReady` low for 1+HOLD_CYCLES cycles.
- Four `outSignalEn` writes of 1,2,3,4 with `devOutReady`=0. Required: FIFO full; one 10 pulse after the fourth write; then `devOutReady`=1 drains 1,2,3,4 in order, one per cycle.
- Fifth write of 5 while full with no pop. With `IO_OVERFLOW_IRQ_EN`: 11 pulse, 5 never appears on `devOutData`. Without it: no pulse, 5 still dropped.
- Full FIFO, `outSignalEn` with `devOutReady`=1 in the same cycle, writing 9. Required: head pops; 9 is enqueued at the tail; occupancy stays at 4; no 11 and no new 10.
- Input accept and overflow on the same edge. Required: 11 on the next cycle, 01 on the cycle after; neither lost.
- Assert reset for one cycle with 3 entries queued and a pending 01. Required: `devOutValid`=0, `interruptSignal`=00 immediately; no stale pulse after release.
